// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared 24-word data memory.
// Port A (load/store) and port B (loader/debug) each get one IDLE->ACC->RESP pass per grant.
module data_mem_arbiter #(
    parameter int DEPTH = 24,
    parameter int DW    = 16,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output logic          mem_read,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_access_addr,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_read_data,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_t        state, state_nxt;
    logic          last_b;
    logic          grant_b;
    logic          start;
    logic          l_b;
    logic          l_we;
    logic          l_err;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [AW-1:0] sel_addr;

    // On a tie the port that was not granted last wins; a lone requester always wins.
    assign grant_b  = b_req && (!a_req || !last_b);
    assign start    = (state == IDLE) && (a_req || b_req);
    assign sel_addr = grant_b ? b_addr : a_addr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_req || b_req) state_nxt = ACC;
            ACC:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b  <= 1'b1;
            l_b     <= 1'b0;
            l_we    <= 1'b0;
            l_err   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (start) begin
            last_b  <= grant_b;
            l_b     <= grant_b;
            l_we    <= grant_b ? b_we : a_we;
            l_addr  <= sel_addr;
            l_wdata <= grant_b ? b_wdata : a_wdata;
            l_err   <= (sel_addr >= DEPTH_W);
        end
    end

    // Read data is captured at the closing edge of ACC so it is valid alongside the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (state == ACC && !l_we) begin
            if (l_b) b_rdata <= l_err ? '0 : mem_read_data;
            else     a_rdata <= l_err ? '0 : mem_read_data;
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write_en    = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        if (state == ACC && !l_err) begin
            mem_read        = !l_we;
            mem_write_en    = l_we;
            mem_access_addr = l_addr;
            mem_write_data  = l_wdata;
        end
    end

    assign a_ack = (state == RESP) && !l_b;
    assign b_ack = (state == RESP) && l_b;
    assign a_err = a_ack && l_err;
    assign b_err = b_ack && l_err;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: behavioural memory, predicted-result queues per port,
// and an ack monitor that pops and compares each completion.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        a_ack, a_err, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_read, mem_write_en, busy;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Entry layout: {is_read, err, rdata}
    logic [17:0] exp_a_q[$];
    logic [17:0] exp_b_q[$];
    int          ack_order[$];
    int          ack_cyc[$];

    logic [15:0] env_mem[32];
    logic [15:0] ref_mem[32];
    bit          env_init = 1'b0;
    logic [15:0] mdl_a = '0, mdl_b = '0;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write_en(mem_write_en),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model (5-bit decode) ----------------
    function automatic logic [15:0] init_val(int i);
        return 16'h5A00 + 16'(i);
    endfunction

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (mem_write_en) begin
            env_mem[mem_access_addr[4:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = env_mem[mem_access_addr[4:0]];

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [17:0] e;
        if (rst === 1'b1) begin
            if (a_ack || b_ack) chk("ack_overlap", 32'(a_ack & b_ack), 0);
            if (a_err && !a_ack) chk("a_err_without_ack", 32'(a_err), 0);
            if (b_err && !b_ack) chk("b_err_without_ack", 32'(b_err), 0);
            if (a_ack) begin
                ack_order.push_back(0);
                ack_cyc.push_back(cyc);
                if (exp_a_q.size() == 0) chk("a_ack_spurious", 32'(a_ack), 0);
                else begin
                    e = exp_a_q.pop_front();
                    chk("a_err", 32'(a_err), 32'(e[16]));
                    if (e[17] && !e[16]) chk("a_rdata_at_ack", 32'(a_rdata), 32'(e[15:0]));
                end
            end
            if (b_ack) begin
                ack_order.push_back(1);
                ack_cyc.push_back(cyc);
                if (exp_b_q.size() == 0) chk("b_ack_spurious", 32'(b_ack), 0);
                else begin
                    e = exp_b_q.pop_front();
                    chk("b_err", 32'(b_err), 32'(e[16]));
                    if (e[17] && !e[16]) chk("b_rdata_at_ack", 32'(b_rdata), 32'(e[15:0]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [17:0] predict(input bit pb, input bit we, input logic [15:0] addr,
                                            input logic [15:0] wdata);
        bit          err;
        logic [15:0] rd;
        err = (addr >= 16'd24);
        rd  = 16'h0;
        if (we) begin
            if (!err) ref_mem[addr[4:0]] = wdata;
        end else begin
            rd = err ? 16'h0 : ref_mem[addr[4:0]];
            if (pb) mdl_b = rd;
            else    mdl_a = rd;
        end
        return {!we, err, rd};
    endfunction

    task automatic do_txn(input bit pb, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        logic [17:0] e;
        bit          got;
        int          ack_k, en_cnt, en_k;
        logic [15:0] en_addr, en_wd;
        logic        en_we;
        e = predict(pb, we, addr, wdata);
        if (pb) exp_b_q.push_back(e);
        else    exp_a_q.push_back(e);
        @(posedge clk); #1;
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        got = 0; ack_k = 0; en_cnt = 0; en_k = 0; en_addr = '0; en_wd = '0; en_we = 0;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (mem_read || mem_write_en) begin
                en_cnt++; en_k = k; en_addr = mem_access_addr; en_wd = mem_write_data; en_we = mem_write_en;
            end
            if (pb ? b_ack : a_ack) begin got = 1; ack_k = k; end
        end
        chk("ack_seen", 32'(got), 1);
        if (got) chk("ack_latency", ack_k, 3);
        chk("mem_en_cycles", en_cnt, e[16] ? 0 : 1);
        if (!e[16] && en_cnt == 1) begin
            chk("mem_en_cycle", en_k, 2);
            chk("mem_addr", 32'(en_addr), 32'(addr));
            chk("mem_we", 32'(en_we), 32'(we));
            if (we) chk("mem_wdata", 32'(en_wd), 32'(wdata));
        end
        @(posedge clk); #1;
        if (pb) b_req = 0;
        else    a_req = 0;
        @(negedge clk);
        chk("a_rdata_hold", 32'(a_rdata), 32'(mdl_a));
        chk("b_rdata_hold", 32'(b_rdata), 32'(mdl_b));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_acks"}, 32'({a_ack, b_ack, a_err, b_err}), 0);
        chk({tag, "_mem_en"}, 32'({mem_read, mem_write_en}), 0);
        chk({tag, "_mem_addr"}, 32'(mem_access_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_write_data), 0);
        chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit got;
        int ac, bc, t1;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

        // Reset values
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1 rst = 1;

        // A write 5 / read back
        do_txn(0, 1, 16'd5, 16'hBEEF);
        do_txn(0, 0, 16'd5, 16'h0);

        // Both requesting from reset: A, B, A, B
        @(posedge clk); #1;
        rst = 0; mdl_a = '0; mdl_b = '0;
        a_req = 1; a_we = 0; a_addr = 16'd1;
        b_req = 1; b_we = 0; b_addr = 16'd2;
        exp_a_q.push_back(predict(0, 0, 16'd1, 16'h0));
        exp_a_q.push_back(predict(0, 0, 16'd1, 16'h0));
        exp_b_q.push_back(predict(1, 0, 16'd2, 16'h0));
        exp_b_q.push_back(predict(1, 0, 16'd2, 16'h0));
        ack_order.delete(); ack_cyc.delete();
        @(posedge clk); #1 rst = 1;
        ac = 0; bc = 0;
        for (int k = 0; k < 40 && (a_req || b_req); k++) begin
            @(negedge clk);
            if (a_ack) ac++;
            if (b_ack) bc++;
            @(posedge clk); #1;
            if (ac == 2) a_req = 0;
            if (bc == 2) b_req = 0;
        end
        chk("rr_ack_count", ack_order.size(), 4);
        if (ack_order.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", ack_order[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // Out-of-range on B: read 24 clears b_rdata, write 0x0118 blocked
        do_txn(1, 0, 16'd24, 16'h0);
        do_txn(1, 1, 16'h0118, 16'hDEAD);
        do_txn(1, 0, 16'd24, 16'h0);

        // a_rdata holds across B's write; later A read sees it
        do_txn(0, 0, 16'd3, 16'h0);
        do_txn(1, 1, 16'd3, 16'h1234);
        do_txn(0, 0, 16'd3, 16'h0);

        // Reset during ACC of an A write aborts it
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 16'd7; a_wdata = 16'hAAAA;
        @(negedge clk);
        @(posedge clk); #1;
        chk("abort_we_in_acc", 32'(mem_write_en), 1);
        rst = 0;
        #1;
        a_req = 0;
        mdl_a = '0; mdl_b = '0;
        chk_outputs_zero("abort");
        @(posedge clk); #1 rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(a_ack), 0);
        end
        do_txn(0, 0, 16'd7, 16'h0);

        // A holds req after ack; B arrives during A's second transaction
        exp_a_q.push_back(predict(0, 0, 16'd10, 16'h0));
        exp_a_q.push_back(predict(0, 0, 16'd10, 16'h0));
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 16'd10;
        got = 0; t1 = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (a_ack) begin got = 1; t1 = cyc; end
        end
        chk("hold_first_ack", 32'(got), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_req = 1; b_we = 0; b_addr = 16'd11;
        exp_b_q.push_back(predict(1, 0, 16'd11, 16'h0));
        @(negedge clk);
        @(negedge clk);
        chk("hold_second_ack", 32'(a_ack), 1);
        chk("hold_ack_gap", cyc - t1, 3);
        t1 = cyc;
        @(posedge clk); #1 a_req = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (b_ack) got = 1;
        end
        chk("hold_b_ack", 32'(got), 1);
        chk("hold_b_gap", cyc - t1, 3);
        @(posedge clk); #1 b_req = 0;
        @(negedge clk);
        chk("hold_a_rdata", 32'(a_rdata), 32'(mdl_a));
        chk("hold_b_rdata", 32'(b_rdata), 32'(mdl_b));

        repeat (3) @(negedge clk);
        chk("exp_a_drained", exp_a_q.size(), 0);
        chk("exp_b_drained", exp_b_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
